// File: rtl/normalizer_pipe.sv
// normalizer_pipe
// Two-stage pipelined significand normaliser. It finds the leading one of an
// unsigned significand and shifts it so that the leading one lands at bit
// NORM_POS. The exponent is adjusted to match, and the block reports sticky,
// zero, underflow and overflow. Valid/ready handshakes are used on both sides.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in_valid  input beat valid
//   in_ready  block can accept an input beat this cycle
//   sig       unnormalised significand  [WIDTH-1:0]
//   ex_a      biased exponent of sig     [EXP_W-1:0]
//   out_valid result valid
//   out_ready downstream accepts the result
//   sig_norm  normalised significand     [WIDTH-1:0]
//   ex_norm   adjusted exponent          [EXP_W-1:0]
//   sticky    OR of the bits lost on a right shift
//   zero      input significand was zero
//   uflow     left shift was limited by the exponent (denormal result)
//   oflow     exponent exceeded its maximum
module normalizer_pipe #(
   parameter int WIDTH    = 32,
   parameter int EXP_W    = 8,
   parameter int NORM_POS = 23
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] sig,
   input  logic [EXP_W-1:0] ex_a,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sig_norm,
   output logic [EXP_W-1:0] ex_norm,
   output logic             sticky,
   output logic             zero,
   output logic             uflow,
   output logic             oflow
);

   localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   // Exponent/shift arithmetic width: wide enough for either operand plus a
   // carry, so sums and differences never wrap.
   localparam int AW = ((EXP_W > PW) ? EXP_W : PW) + 2;

   // ---------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------
   logic s1_valid;
   logic s2_valid;
   logic s1_adv;
   logic s2_adv;

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

   // ---------------------------------------------------------------
   // Stage 1: leading-one detection
   // ---------------------------------------------------------------
   logic [PW-1:0] lead_pos;

   // The highest set bit wins because later iterations overwrite earlier ones.
   always_comb begin
      lead_pos = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (sig[i]) begin
            lead_pos = PW'(i);
         end
      end
   end

   logic [WIDTH-1:0] s1_sig;
   logic [EXP_W-1:0] s1_ex;
   logic [PW-1:0]    s1_pos;
   logic             s1_zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sig   <= '0;
         s1_ex    <= '0;
         s1_pos   <= '0;
         s1_zero  <= 1'b0;
      end else if (s1_adv) begin
         // An empty or drained S1 either takes the new beat or goes idle.
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sig  <= sig;
            s1_ex   <= ex_a;
            s1_pos  <= lead_pos;
            s1_zero <= (sig == '0);
         end
      end
   end

   // ---------------------------------------------------------------
   // Stage 2: shift and exponent adjust
   // ---------------------------------------------------------------
   logic [AW-1:0] ex_ext;
   logic [AW-1:0] pos_ext;
   logic [AW-1:0] norm_ext;
   logic [AW-1:0] r_amt;
   logic [AW-1:0] l_amt;
   logic [AW-1:0] ex_sum;

   assign ex_ext   = AW'(s1_ex);
   assign pos_ext  = AW'(s1_pos);
   assign norm_ext = AW'(NORM_POS);
   assign r_amt    = pos_ext - norm_ext;
   assign l_amt    = norm_ext - pos_ext;
   assign ex_sum   = ex_ext + r_amt;

   logic [WIDTH-1:0] n_sig;
   logic [EXP_W-1:0] n_ex;
   logic             n_sticky;
   logic             n_zero;
   logic             n_uflow;
   logic             n_oflow;

   always_comb begin
      n_sig    = s1_sig;
      n_ex     = s1_ex;
      n_sticky = 1'b0;
      n_zero   = 1'b0;
      n_uflow  = 1'b0;
      n_oflow  = 1'b0;
      if (s1_zero) begin
         n_sig  = '0;
         n_ex   = '0;
         n_zero = 1'b1;
      end else if (pos_ext > norm_ext) begin
         // Any bit above EXP_W in the sum means the exponent saturated.
         if (ex_sum[AW-1:EXP_W] != '0) begin
            n_sig   = '0;
            n_ex    = '1;
            n_oflow = 1'b1;
         end else begin
            n_sig    = s1_sig >> r_amt;
            n_sticky = |(s1_sig & ~({WIDTH{1'b1}} << r_amt));
            n_ex     = ex_sum[EXP_W-1:0];
         end
      end else if (pos_ext < norm_ext) begin
         if (l_amt <= ex_ext) begin
            n_sig = s1_sig << l_amt;
            n_ex  = s1_ex - l_amt[EXP_W-1:0];
         end else begin
            // Exponent cannot go below zero: shift only as far as it allows.
            n_sig   = s1_sig << s1_ex;
            n_ex    = '0;
            n_uflow = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         sig_norm <= '0;
         ex_norm  <= '0;
         sticky   <= 1'b0;
         zero     <= 1'b0;
         uflow    <= 1'b0;
         oflow    <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         // Outputs hold their last value while idle or stalled.
         if (s1_valid) begin
            sig_norm <= n_sig;
            ex_norm  <= n_ex;
            sticky   <= n_sticky;
            zero     <= n_zero;
            uflow    <= n_uflow;
            oflow    <= n_oflow;
         end
      end
   end

endmodule

// File: tb/tb_normalizer_pipe.sv
// Testbench for normalizer_pipe (WIDTH=32, EXP_W=8, NORM_POS=23).
// A scoreboard queue holds expected results. Each result comes either from a
// directed table or from an arithmetic reference model.
module tb_normalizer_pipe;

   localparam int WIDTH = 32;
   localparam int EXP_W = 8;
   localparam int NP    = 23;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] sig;
   logic [EXP_W-1:0] ex_a;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sig_norm;
   logic [EXP_W-1:0] ex_norm;
   logic             sticky;
   logic             zero;
   logic             uflow;
   logic             oflow;

   always #5 clk = ~clk;

   normalizer_pipe #(.WIDTH(WIDTH), .EXP_W(EXP_W), .NORM_POS(NP)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sig       (sig),
      .ex_a      (ex_a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sig_norm  (sig_norm),
      .ex_norm   (ex_norm),
      .sticky    (sticky),
      .zero      (zero),
      .uflow     (uflow),
      .oflow     (oflow)
   );

   typedef struct packed {
      logic [31:0] s;
      logic [7:0]  e;
      logic        st;
      logic        z;
      logic        u;
      logic        o;
   } res_t;

   typedef struct {
      res_t r;
      int   acc;
      bit   strict;
   } sb_t;

   sb_t  sb[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   bit   stall_prev = 1'b0;
   res_t snap;
   bit   strict_lat = 1'b0;
   bit   use_tab = 1'b0;
   res_t tab_exp;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic res_t outs();
      return {sig_norm, ex_norm, sticky, zero, uflow, oflow};
   endfunction

   // Reference: plain integer arithmetic on the normalisation rules.
   function automatic res_t model(input logic [31:0] s, input logic [7:0] e);
      res_t   r;
      longint sv;
      longint p2;
      int     ev;
      int     msb;
      int     sh;
      r  = '0;
      sv = longint'(s);
      ev = int'(e);
      if (sv == 0) begin
         r.z = 1'b1;
         return r;
      end
      msb = 0;
      while (sv >= (longint'(1) << (msb + 1))) msb++;
      if (msb > NP) begin
         sh = msb - NP;
         p2 = longint'(1) << sh;
         if (ev + sh > 255) begin
            r.e = 8'hFF;
            r.o = 1'b1;
         end else begin
            r.s  = 32'(sv / p2);
            r.st = (sv % p2) != 0;
            r.e  = 8'(ev + sh);
         end
      end else if (msb < NP) begin
         sh = NP - msb;
         if (sh <= ev) begin
            r.s = 32'(sv * (longint'(1) << sh));
            r.e = 8'(ev - sh);
         end else begin
            r.s = 32'(sv * (longint'(1) << ev));
            r.e = 8'h00;
            r.u = 1'b1;
         end
      end else begin
         r.s = s;
         r.e = e;
      end
      return r;
   endfunction

   // One clock cycle. Inputs are already driven. Sampling happens on the
   // falling edge, and the task returns 1 time unit after the rising edge.
   task automatic step(output bit acc);
      sb_t ent;
      @(negedge clk);
      if (stall_prev) begin
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_outputs", 64'(outs()), 64'(snap));
      end
      check("in_ready", 64'(in_ready), 64'(!(sb.size() == 2 && !out_ready)));
      if (out_valid && out_ready) begin
         check("result_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            ent = sb.pop_front();
            check("result", 64'(outs()), 64'(ent.r));
            if (ent.strict) check("latency", 64'(cyc - ent.acc), 64'd2);
         end
      end
      acc = in_valid && in_ready;
      if (acc) begin
         ent.r      = use_tab ? tab_exp : model(sig, ex_a);
         ent.acc    = cyc;
         ent.strict = strict_lat;
         sb.push_back(ent);
      end
      stall_prev = out_valid && !out_ready;
      snap       = outs();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain();
      bit a;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 10 && sb.size() != 0; k++) step(a);
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   // Directed table: sig, ex_a, expected result.
   logic [31:0] d_sig [9] = '{32'h007C9C00, 32'h0006E800, 32'h006147AF, 32'h01800001,
                              32'h80000000, 32'h00000001, 32'h00000000, 32'h00800000,
                              32'h00FFFFFF};
   logic [7:0]  d_ex  [9] = '{8'h87, 8'h8A, 8'h7E, 8'h10, 8'hF8, 8'h05, 8'h40, 8'h33, 8'h00};
   res_t        d_res [9] = '{{32'h00F93800, 8'h86, 4'b0000},
                              {32'h00DD0000, 8'h85, 4'b0000},
                              {32'h00C28F5E, 8'h7D, 4'b0000},
                              {32'h00C00000, 8'h11, 4'b1000},
                              {32'h00000000, 8'hFF, 4'b0001},
                              {32'h00000020, 8'h00, 4'b0010},
                              {32'h00000000, 8'h00, 4'b0100},
                              {32'h00800000, 8'h33, 4'b0000},
                              {32'h00FFFFFF, 8'h00, 4'b0000}};

   initial begin
      bit acc;
      int r;
      rst       = 1'b1;
      in_valid  = 1'b0;
      sig       = '0;
      ex_a      = '0;
      out_ready = 1'b1;
      #3;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_outputs", 64'(outs()), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed vectors issued back to back with out_ready held high.
      strict_lat = 1'b1;
      use_tab    = 1'b1;
      for (int i = 0; i < 9; i++) begin
         sig      = d_sig[i];
         ex_a     = d_ex[i];
         tab_exp  = d_res[i];
         in_valid = 1'b1;
         step(acc);
         check("dir_accept", 64'(acc), 64'd1);
      end
      drain();

      // Backpressure: the third beat must be refused while both stages hold data.
      strict_lat = 1'b0;
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sig     = d_sig[i];
         ex_a    = d_ex[i];
         tab_exp = d_res[i];
         step(acc);
         check("bp_accept", 64'(acc), (i < 2) ? 64'd1 : 64'd0);
      end
      for (int i = 0; i < 3; i++) begin
         step(acc);
         check("bp_stalled", 64'(acc), 64'd0);
      end
      out_ready = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 5 && !acc; k++) step(acc);
      check("bp_third_taken", 64'(acc), 64'd1);
      drain();

      // Reset with two beats in flight.
      strict_lat = 1'b1;
      in_valid   = 1'b1;
      for (int i = 3; i < 5; i++) begin
         sig     = d_sig[i];
         ex_a    = d_ex[i];
         tab_exp = d_res[i];
         step(acc);
      end
      check("pre_reset_valid", 64'(out_valid), 64'd1);
      #2;
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      check("async_reset_valid", 64'(out_valid), 64'd0);
      check("async_reset_outputs", 64'(outs()), 64'd0);
      sb.delete();
      stall_prev = 1'b0;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(acc);
         check("no_stale", 64'(out_valid), 64'd0);
      end
      sig      = d_sig[0];
      ex_a     = d_ex[0];
      tab_exp  = d_res[0];
      in_valid = 1'b1;
      step(acc);
      in_valid = 1'b0;
      drain();

      // Randomised traffic against the reference model.
      use_tab    = 1'b0;
      strict_lat = 1'b0;
      in_valid   = 1'b0;
      acc        = 1'b1;
      for (int k = 0; k < 400; k++) begin
         if (!in_valid || acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r == 0) sig = '0;
            else        sig = $urandom >> $urandom_range(0, 31);
            r = $urandom_range(0, 5);
            if (r == 0)      ex_a = 8'h00;
            else if (r == 1) ex_a = 8'hFF;
            else if (r == 2) ex_a = 8'($urandom_range(0, 8));
            else             ex_a = 8'($urandom_range(0, 255));
         end
         out_ready = ($urandom_range(0, 3) != 0);
         step(acc);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
